// File: rtl/stf_stream_gen_if.sv
// stf_stream_gen_if: AXI-Stream style master handshake bundle for the STF sample stream.
//   m_tvalid : sample valid (master -> slave)
//   m_tready : downstream ready (slave -> master)
//   m_tdata  : complex sample, I in upper SAMPLE_W bits, Q in lower SAMPLE_W bits
//   m_tlast  : final sample of a burst
// Modports: master (generator side), slave (consumer side).
interface stf_stream_gen_if #(
  parameter int unsigned SAMPLE_W = 16
);
  logic                    m_tvalid;
  logic                    m_tready;
  logic [2*SAMPLE_W-1:0]   m_tdata;
  logic                    m_tlast;

  modport master (
    output m_tvalid,
    output m_tdata,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tvalid,
    input  m_tdata,
    input  m_tlast,
    output m_tready
  );
endinterface

// File: rtl/stf_stream_gen.sv
// stf_stream_gen: emits a burst of NUM_REP passes over a 16-entry complex (I,Q) table.
// Ports:
//   clk    : clock, rising edge
//   rstn   : synchronous active-low reset
//   start  : single-cycle burst request (honoured in idle only)
//   abort  : end the burst immediately, no done pulse
//   m      : stf_stream_gen_if.master stream (m_tvalid/m_tready/m_tdata/m_tlast)
//   busy   : burst in progress (RUN or DONE)
//   done   : one-cycle pulse after the last sample is accepted
// Optional feature macro STF_STREAM_GEN_WINDOW_EN: halves the amplitude of the first and
// last sample of each burst (boundary window).
module stf_stream_gen #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned NUM_REP  = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  stf_stream_gen_if.master      m,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam int unsigned Shift   = 16 - SAMPLE_W;
  localparam logic [3:0]  LastRep = 4'(NUM_REP - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  rep_q, rep_d;

  logic        run;
  logic        hs;
  logic        is_last;
  logic        win;
  logic [31:0] entry;
  logic signed [15:0] i_full, q_full, i_sh, q_sh;

  assign run     = (state_q == StRun);
  assign hs      = run && m.m_tready;
  assign is_last = (idx_q == 4'd15) && (rep_q == LastRep);

  // Entries 8..15 repeat 0..7, so only the low three index bits select the value.
  always_comb begin
    entry = 32'h0;
    unique case (idx_q[2:0])
      3'd0: entry = {16'hfd0e, 16'hfd0e};
      3'd1: entry = {16'h0000, 16'hfbd6};
      3'd2: entry = {16'h02f2, 16'hfd0e};
      3'd3: entry = {16'h042a, 16'h0000};
      3'd4: entry = {16'h02f2, 16'h02f2};
      3'd5: entry = {16'h0000, 16'h042a};
      3'd6: entry = {16'hfd0e, 16'h02f2};
      3'd7: entry = {16'hfbd6, 16'h0000};
      default: entry = 32'h0;
    endcase
  end

`ifdef STF_STREAM_GEN_WINDOW_EN
  assign win = ((rep_q == 4'd0) && (idx_q == 4'd0)) || is_last;
`else
  assign win = 1'b0;
`endif

  always_comb begin
    i_full = $signed(entry[31:16]);
    q_full = $signed(entry[15:0]);
    i_sh   = i_full >>> Shift;
    q_sh   = q_full >>> Shift;
    if (win) begin
      i_sh = i_sh >>> 1;
      q_sh = q_sh >>> 1;
    end
  end

  // Outputs are decoded from registered state, so data/last hold while stalled.
  assign m.m_tvalid = run;
  assign m.m_tlast  = run && is_last;
  assign m.m_tdata  = run ? {i_sh[SAMPLE_W-1:0], q_sh[SAMPLE_W-1:0]} : '0;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) state_d = StRun;
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          idx_d   = 4'd0;
          rep_d   = 4'd0;
        end else if (hs) begin
          if (is_last) begin
            state_d = StDone;
            idx_d   = 4'd0;
            rep_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) rep_d = rep_q + 4'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = 4'd0;
        rep_d   = 4'd0;
      end
      default: begin
        state_d = StIdle;
        idx_d   = 4'd0;
        rep_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      rep_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
    end
  end

endmodule

// File: tb/tb_stf_stream_gen.sv
module tb_stf_stream_gen;

  logic clk = 1'b0;
  logic rstn;
  logic start, abort, busy, done;
  logic ws, wabort, wbusy, wdone;

  int n_cmp = 0;
  int n_err = 0;

  localparam int TI[8] = '{-754, 0, 754, 1066, 754, 0, -754, -1066};
  localparam int TQ[8] = '{-754, -1066, -754, 0, 754, 1066, 754, 0};

  always #5 clk = ~clk;

  stf_stream_gen_if #(.SAMPLE_W(16)) st_if ();
  stf_stream_gen_if #(.SAMPLE_W(12)) w_if ();

  stf_stream_gen #(.SAMPLE_W(16), .NUM_REP(10)) u_dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .abort (abort),
    .m     (st_if.master),
    .busy  (busy),
    .done  (done)
  );

  stf_stream_gen #(.SAMPLE_W(12), .NUM_REP(2)) u_dut12 (
    .clk   (clk),
    .rstn  (rstn),
    .start (ws),
    .abort (wabort),
    .m     (w_if.master),
    .busy  (wbusy),
    .done  (wdone)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference sample for beat number `beat` of a `total`-beat burst at width `sw`.
  function automatic logic [31:0] exp_sample(input int sw, input int beat, input int total);
    int e, iv, qv, mask;
    e  = beat % 8;
    iv = TI[e] >>> (16 - sw);
    qv = TQ[e] >>> (16 - sw);
`ifdef STF_STREAM_GEN_WINDOW_EN
    if (beat == 0 || beat == total - 1) begin
      iv = iv >>> 1;
      qv = qv >>> 1;
    end
`else
    if (total < 0) iv = 0;
`endif
    mask = (1 << sw) - 1;
    return 32'(((iv & mask) << sw) | (qv & mask));
  endfunction

  // Full-rate burst on the default instance; ign_at pulses start mid-burst, abort_at /
  // reset_at cut the burst short at that beat (-1 disables).
  task automatic run_burst(input int ign_at, input int abort_at, input int reset_at);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int b = 0; b < 160; b++) begin
      if (b == reset_at) begin
        rstn = 1'b0;
        tick();
        check_eq("rst_valid", 32'(st_if.m_tvalid), 32'd0);
        check_eq("rst_last", 32'(st_if.m_tlast), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_data", st_if.m_tdata, 32'd0);
        rstn = 1'b1;
        repeat (3) begin
          tick();
          check_eq("rst_nodone", 32'({done, busy, st_if.m_tvalid}), 32'd0);
        end
        return;
      end
      check_eq($sformatf("valid_b%0d", b), 32'(st_if.m_tvalid), 32'd1);
      check_eq($sformatf("data_b%0d", b), st_if.m_tdata, exp_sample(16, b, 160));
      check_eq($sformatf("last_b%0d", b), 32'(st_if.m_tlast), 32'(b == 159));
      if (b == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_valid", 32'(st_if.m_tvalid), 32'd0);
        check_eq("abort_last", 32'(st_if.m_tlast), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        tick();
        check_eq("abort_nodone", 32'(done), 32'd0);
        return;
      end
      if (b == ign_at) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check_eq("end_done", 32'(done), 32'd1);
    check_eq("end_busy", 32'(busy), 32'd1);
    check_eq("end_valid", 32'(st_if.m_tvalid), 32'd0);
    tick();
    check_eq("idle_done", 32'(done), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int hs, cyc;
    logic pv, pr, pl;
    logic [31:0] pd;
    rstn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    ws = 1'b0;
    wabort = 1'b0;
    st_if.m_tready = 1'b1;
    w_if.m_tready = 1'b1;
    repeat (3) tick();
    check_eq("reset_valid", 32'(st_if.m_tvalid), 32'd0);
    check_eq("reset_last", 32'(st_if.m_tlast), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_data", st_if.m_tdata, 32'd0);
    rstn = 1'b1;
    tick();

    // Abort beats start in idle.
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check_eq("prio_busy", 32'(busy), 32'd0);
    check_eq("prio_valid", 32'(st_if.m_tvalid), 32'd0);

    // Full-rate burst; a start pulse at beat 30 must not disturb it.
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef STF_STREAM_GEN_WINDOW_EN
    check_eq("first_beat", st_if.m_tdata, 32'hfe87fe87);
`else
    check_eq("first_beat", st_if.m_tdata, 32'hfd0efd0e);
`endif
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    run_burst(30, -1, -1);

    // Narrow instance: 12-bit samples, two passes.
    ws = 1'b1;
    tick();
    ws = 1'b0;
    for (int b = 0; b < 32; b++) begin
      check_eq("w_valid", 32'(w_if.m_tvalid), 32'd1);
      check_eq($sformatf("w_data_b%0d", b), 32'(w_if.m_tdata), exp_sample(12, b, 32));
      check_eq("w_last", 32'(w_if.m_tlast), 32'(b == 31));
      if (b == 3) check_eq("w_entry3", 32'(w_if.m_tdata), 32'h00042000);
      if (b == 7) check_eq("w_entry7", 32'(w_if.m_tdata), 32'h00fbd000);
      tick();
    end
    check_eq("w_done", 32'(wdone), 32'd1);
    tick();

    // Random backpressure.
    start = 1'b1;
    tick();
    start = 1'b0;
    hs = 0;
    cyc = 0;
    pv = 1'b0;
    pr = 1'b1;
    pl = 1'b0;
    pd = '0;
    while (hs < 160 && cyc < 3000) begin
      check_eq("bp_valid", 32'(st_if.m_tvalid), 32'd1);
      if (pv && !pr) begin
        check_eq("bp_hold_data", st_if.m_tdata, pd);
        check_eq("bp_hold_last", 32'(st_if.m_tlast), 32'(pl));
      end
      check_eq($sformatf("bp_data_h%0d", hs), st_if.m_tdata, exp_sample(16, hs, 160));
      check_eq("bp_last", 32'(st_if.m_tlast), 32'(hs == 159));
      st_if.m_tready = 1'($urandom_range(0, 1));
      pv = st_if.m_tvalid;
      pr = st_if.m_tready;
      pd = st_if.m_tdata;
      pl = st_if.m_tlast;
      if (st_if.m_tvalid && st_if.m_tready) hs++;
      cyc++;
      tick();
    end
    check_eq("bp_handshakes", 32'(hs), 32'd160);
    check_eq("bp_done", 32'(done), 32'd1);
    st_if.m_tready = 1'b1;
    tick();

    // Abort after 40 handshakes, then a clean full burst.
    run_burst(-1, 40, -1);
    run_burst(-1, -1, -1);

    // Reset mid-burst at beat 50.
    run_burst(-1, -1, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
